// File: rtl/crop_job_scheduler.sv
// crop_job_scheduler: queues crop requests and runs each through crop_plus_gaussian,
// emitting one status word per job.
module crop_job_scheduler #(
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int FIFO_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                                     ap_clk,
    input  logic                                     ap_rst_n,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] req_TDATA,
    input  logic                                     req_TVALID,
    output logic                                     req_TREADY,
    output logic [IMG_ROW_BITWIDTH-1:0]              crop_Y1_TDATA,
    output logic                                     crop_Y1_TVALID,
    input  logic                                     crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0]              crop_X1_TDATA,
    output logic                                     crop_X1_TVALID,
    input  logic                                     crop_X1_TREADY,
    output logic                                     core_ap_start,
    input  logic                                     core_ap_idle,
    input  logic                                     core_ap_done,
    output logic [31:0]                              status_TDATA,
    output logic                                     status_TVALID,
    input  logic                                     status_TREADY,
    output logic                                     busy,
    output logic [15:0]                              jobs_done
);
    localparam int RW = IMG_ROW_BITWIDTH;
    localparam int CW = IMG_COL_BITWIDTH;
    localparam int DW = RW + CW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [RW-1:0] Y_MAX    = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] X_MAX    = CW'(IN_COLS - OUT_COLS);
    localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND_COORD, START, WAIT_DONE, REPORT} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            nempty_q, req_tready_q, req_tready_d, busy_q, busy_d;
    logic [RW-1:0]   y_q, y_d;
    logic [CW-1:0]   x_q, x_d;
    logic            y_vld_q, y_vld_d, x_vld_q, x_vld_d, clamped_q, clamped_d;
    logic            start_q, start_d, status_vld_q, status_vld_d;
    logic [31:0]     tmo_cnt_q, tmo_cnt_d, status_data_q, status_data_d;
    logic [15:0]     job_id_q, job_id_d, jobs_done_q, jobs_done_d;
    logic            push, pop;
    logic [DW-1:0]   head;
    logic [RW-1:0]   head_y;
    logic [CW-1:0]   head_x;

    // Occupancy is seen through a one-cycle-late flag, giving two edges from request to crop TVALID.
    assign push   = req_TVALID && req_tready_q;
    assign pop    = (state_q == IDLE) && nempty_q;
    assign head   = mem_q[rd_ptr_q];
    assign head_y = head[DW-1:CW];
    assign head_x = head[CW-1:0];

    always_comb begin
        state_d       = state_q;
        y_d           = y_q;
        x_d           = x_q;
        y_vld_d       = y_vld_q;
        x_vld_d       = x_vld_q;
        clamped_d     = clamped_q;
        start_d       = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        status_vld_d  = status_vld_q;
        status_data_d = status_data_q;
        job_id_d      = job_id_q;
        jobs_done_d   = jobs_done_q;
        wr_ptr_d      = wr_ptr_q + AW'(push);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        count_d       = count_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE: if (pop) begin
                y_d       = (head_y > Y_MAX) ? Y_MAX : head_y;
                x_d       = (head_x > X_MAX) ? X_MAX : head_x;
                clamped_d = (head_y > Y_MAX) || (head_x > X_MAX);
                y_vld_d   = 1'b1;
                x_vld_d   = 1'b1;
                state_d   = SEND_COORD;
            end
            SEND_COORD: begin
                y_vld_d = y_vld_q && !crop_Y1_TREADY;
                x_vld_d = x_vld_q && !crop_X1_TREADY;
                state_d = (!y_vld_d && !x_vld_d) ? START : SEND_COORD;
            end
            START: if (core_ap_idle) begin
                start_d   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (core_ap_done) begin
                    status_vld_d  = 1'b1;
                    status_data_d = {1'b0, clamped_q, 14'd0, job_id_q};
                    state_d       = REPORT;
                end else if (TIMEOUT_CYCLES != 0 && tmo_cnt_q == TMO_LAST) begin
                    status_vld_d  = 1'b1;
                    status_data_d = {1'b1, clamped_q, 14'd0, job_id_q};
                    state_d       = REPORT;
                end
            end
            REPORT: if (status_TREADY) begin
                status_vld_d = 1'b0;
                job_id_d     = job_id_q + 16'd1;
                jobs_done_d  = jobs_done_q + 16'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_tready_d = count_d != (AW+1)'(FIFO_DEPTH);
        busy_d       = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge ap_clk) begin
        if (push) mem_q[wr_ptr_q] <= req_TDATA;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            nempty_q      <= 1'b0;
            req_tready_q  <= 1'b0;
            busy_q        <= 1'b0;
            y_q           <= '0;
            x_q           <= '0;
            y_vld_q       <= 1'b0;
            x_vld_q       <= 1'b0;
            clamped_q     <= 1'b0;
            start_q       <= 1'b0;
            tmo_cnt_q     <= '0;
            status_vld_q  <= 1'b0;
            status_data_q <= '0;
            job_id_q      <= '0;
            jobs_done_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            nempty_q      <= count_q != '0;
            req_tready_q  <= req_tready_d;
            busy_q        <= busy_d;
            y_q           <= y_d;
            x_q           <= x_d;
            y_vld_q       <= y_vld_d;
            x_vld_q       <= x_vld_d;
            clamped_q     <= clamped_d;
            start_q       <= start_d;
            tmo_cnt_q     <= tmo_cnt_d;
            status_vld_q  <= status_vld_d;
            status_data_q <= status_data_d;
            job_id_q      <= job_id_d;
            jobs_done_q   <= jobs_done_d;
        end
    end

    assign req_TREADY     = req_tready_q;
    assign crop_Y1_TDATA  = y_q;
    assign crop_Y1_TVALID = y_vld_q;
    assign crop_X1_TDATA  = x_q;
    assign crop_X1_TVALID = x_vld_q;
    assign core_ap_start  = start_q;
    assign status_TDATA   = status_data_q;
    assign status_TVALID  = status_vld_q;
    assign busy           = busy_q;
    assign jobs_done      = jobs_done_q;
endmodule

// File: tb/tb_crop_job_scheduler.sv
// tb_crop_job_scheduler: directed scenario tasks for crop_job_scheduler with a
// hand-driven core model; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_crop_job_scheduler;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [19:0] req_TDATA = '0;
    logic        req_TVALID = 1'b0;
    logic        req_TREADY;
    logic [9:0]  crop_Y1_TDATA, crop_X1_TDATA;
    logic        crop_Y1_TVALID, crop_X1_TVALID;
    logic        crop_Y1_TREADY = 1'b1, crop_X1_TREADY = 1'b1;
    logic        core_ap_start;
    logic        core_ap_idle = 1'b1, core_ap_done = 1'b0;
    logic [31:0] status_TDATA;
    logic        status_TVALID;
    logic        status_TREADY = 1'b0;
    logic        busy;
    logic [15:0] jobs_done;
    int checks = 0, failures = 0;

    crop_job_scheduler #(.TIMEOUT_CYCLES(100)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_TDATA(req_TDATA), .req_TVALID(req_TVALID), .req_TREADY(req_TREADY),
        .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
        .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
        .core_ap_start(core_ap_start), .core_ap_idle(core_ap_idle), .core_ap_done(core_ap_done),
        .status_TDATA(status_TDATA), .status_TVALID(status_TVALID), .status_TREADY(status_TREADY),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic apply_reset();
        ap_rst_n = 1'b0;
        req_TVALID = 1'b0;
        req_TDATA = '0;
        crop_Y1_TREADY = 1'b1;
        crop_X1_TREADY = 1'b1;
        core_ap_idle = 1'b1;
        core_ap_done = 1'b0;
        status_TREADY = 1'b0;
        repeat (2) tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [9:0] y, input logic [9:0] x, output bit ok);
        logic rdy;
        ok = 1'b0;
        req_TDATA = {y, x};
        req_TVALID = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            rdy = req_TREADY;
            tick();
            if (rdy) ok = 1'b1;
        end
        req_TVALID = 1'b0;
    endtask

    task automatic run_job(input int done_delay, output logic [9:0] y, output logic [9:0] x,
                           output logic [31:0] st, output int start_w, output bit ok);
        ok = 1'b1;
        start_w = 0;
        for (int n = 0; n < 50 && !crop_Y1_TVALID; n++) tick();
        if (!crop_Y1_TVALID) ok = 1'b0;
        y = crop_Y1_TDATA;
        x = crop_X1_TDATA;
        for (int n = 0; n < 50 && !core_ap_start; n++) tick();
        if (!core_ap_start) ok = 1'b0;
        while (core_ap_start && start_w < 10) begin
            start_w++;
            tick();
        end
        repeat (done_delay) tick();
        core_ap_done = 1'b1;
        tick();
        core_ap_done = 1'b0;
        for (int n = 0; n < 50 && !status_TVALID; n++) tick();
        if (!status_TVALID) ok = 1'b0;
        st = status_TDATA;
        status_TREADY = 1'b1;
        tick();
        status_TREADY = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_TREADY, busy, crop_Y1_TVALID, crop_X1_TVALID, core_ap_start, status_TVALID} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {req_TREADY, busy, crop_Y1_TVALID, crop_X1_TVALID, core_ap_start, status_TVALID});
        end
        checks++;
        if ({crop_Y1_TDATA, crop_X1_TDATA, status_TDATA, jobs_done} !== 68'd0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {crop_Y1_TDATA, crop_X1_TDATA, status_TDATA, jobs_done});
        end
        ap_rst_n = 1'b1;
        tick();
        checks++;
        if (req_TREADY !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready got=%b want=1", req_TREADY);
        end
    endtask

    task automatic test_single();
        logic [9:0] y, x;
        logic [31:0] st;
        int sw;
        bit ok, pok;
        push(10'd37, 10'd59, pok);
        tick();
        checks++;
        if (crop_Y1_TVALID !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got=%b want=0", crop_Y1_TVALID);
        end
        tick();
        checks++;
        if (crop_Y1_TVALID !== 1'b1 || crop_X1_TVALID !== 1'b1) begin
            failures++;
            $display("FAIL single_latency got=%b%b want=11", crop_Y1_TVALID, crop_X1_TVALID);
        end
        run_job(20, y, x, st, sw, ok);
        checks++;
        if (!(ok && pok)) begin
            failures++;
            $display("FAIL single_timeout got=%b%b want=11", ok, pok);
        end
        checks++;
        if ({y, x} !== {10'd37, 10'd59}) begin
            failures++;
            $display("FAIL single_coords got=%0d,%0d want=37,59", y, x);
        end
        checks++;
        if (sw !== 1) begin
            failures++;
            $display("FAIL single_start_width got=%0d want=1", sw);
        end
        checks++;
        if (st !== 32'h0000_0000 || jobs_done !== 16'd1) begin
            failures++;
            $display("FAIL single_status got=%h/%0d want=00000000/1", st, jobs_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ys [3] = '{10'd0, 10'd37, 10'd52};
        logic [9:0] xs [3] = '{10'd0, 10'd59, 10'd112};
        logic [9:0] y, x;
        logic [31:0] st;
        int sw;
        bit ok, pok;
        apply_reset();
        for (int i = 0; i < 3; i++) push(ys[i], xs[i], pok);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_on got=%b want=1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            run_job(3, y, x, st, sw, ok);
            checks++;
            if (!ok || {y, x} !== {ys[i], xs[i]} || st !== 32'(i)) begin
                failures++;
                $display("FAIL b2b_job%0d got=%0d,%0d,%h ok=%b want=%0d,%0d,%h", i, y, x, st, ok, ys[i], xs[i], 32'(i));
            end
        end
        checks++;
        if (busy !== 1'b0 || jobs_done !== 16'd3) begin
            failures++;
            $display("FAIL b2b_end got=busy %b jobs %0d want=busy 0 jobs 3", busy, jobs_done);
        end
    endtask

    task automatic test_clamp();
        logic [9:0] y, x;
        logic [31:0] st;
        int sw;
        bit ok, pok;
        push(10'd70, 10'd150, pok);
        run_job(2, y, x, st, sw, ok);
        checks++;
        if (!ok || {y, x} !== {10'd52, 10'd112}) begin
            failures++;
            $display("FAIL clamp_coords got=%0d,%0d want=52,112", y, x);
        end
        checks++;
        if (st !== 32'h4000_0003) begin
            failures++;
            $display("FAIL clamp_status got=%h want=40000003", st);
        end
    endtask

    task automatic test_fifo_full();
        logic [9:0] y, x;
        logic [31:0] st;
        int sw;
        bit ok, pok, all_ok;
        crop_Y1_TREADY = 1'b0;
        crop_X1_TREADY = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(10'(2 * i + 1), 10'(2 * i + 2), pok);
            all_ok &= pok;
        end
        checks++;
        if (!all_ok || req_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_tready got=ok %b tready %b want=ok 1 tready 0", all_ok, req_TREADY);
        end
        req_TDATA = {10'd11, 10'd12};
        req_TVALID = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_hold got=%b want=0", req_TREADY);
        end
        req_TVALID = 1'b0;
        crop_Y1_TREADY = 1'b1;
        crop_X1_TREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_job(2, y, x, st, sw, ok);
            checks++;
            if (!ok || {y, x} !== {10'(2 * i + 1), 10'(2 * i + 2)} || st !== 32'(4 + i)) begin
                failures++;
                $display("FAIL fifo_job%0d got=%0d,%0d,%h want=%0d,%0d,%h", i, y, x, st, 2 * i + 1, 2 * i + 2, 32'(4 + i));
            end
        end
        checks++;
        if (busy !== 1'b0 || jobs_done !== 16'd9) begin
            failures++;
            $display("FAIL fifo_no_extra got=busy %b jobs %0d want=busy 0 jobs 9", busy, jobs_done);
        end
    endtask

    task automatic test_handshake_order();
        bit pok, bad, saw_start;
        crop_X1_TREADY = 1'b0;
        core_ap_idle = 1'b0;
        push(10'd20, 10'd30, pok);
        for (int n = 0; n < 20 && !crop_Y1_TVALID; n++) tick();
        core_ap_done = 1'b1;
        tick();
        core_ap_done = 1'b0;
        checks++;
        if ({crop_Y1_TVALID, crop_X1_TVALID} !== 2'b01 || crop_X1_TDATA !== 10'd30) begin
            failures++;
            $display("FAIL hs_split got=%b%b x=%0d want=01 x=30", crop_Y1_TVALID, crop_X1_TVALID, crop_X1_TDATA);
        end
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (!crop_X1_TVALID || core_ap_start || status_TVALID) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL hs_x_wait got=bad want=hold");
        end
        crop_X1_TREADY = 1'b1;
        tick();
        saw_start = 1'b0;
        repeat (3) begin
            tick();
            if (core_ap_start) saw_start = 1'b1;
        end
        checks++;
        if (saw_start || crop_X1_TVALID) begin
            failures++;
            $display("FAIL hs_idle_gate got=start %b xv %b want=0 0", saw_start, crop_X1_TVALID);
        end
        core_ap_idle = 1'b1;
        tick();
        checks++;
        if (core_ap_start !== 1'b1) begin
            failures++;
            $display("FAIL hs_start got=%b want=1", core_ap_start);
        end
        tick();
        checks++;
        if (core_ap_start !== 1'b0) begin
            failures++;
            $display("FAIL hs_start_pulse got=%b want=0", core_ap_start);
        end
        repeat (3) tick();
        core_ap_done = 1'b1;
        tick();
        core_ap_done = 1'b0;
        for (int n = 0; n < 20 && !status_TVALID; n++) tick();
        checks++;
        if (!pok || status_TVALID !== 1'b1 || status_TDATA !== 32'h0000_0009) begin
            failures++;
            $display("FAIL hs_status got=%b/%h want=1/00000009", status_TVALID, status_TDATA);
        end
        status_TREADY = 1'b1;
        tick();
        status_TREADY = 1'b0;
    endtask

    task automatic test_timeout_and_reset();
        logic [9:0] y, x;
        logic [31:0] st;
        int sw, n;
        bit ok, pok, saw;
        apply_reset();
        push(10'd10, 10'd10, pok);
        for (int k = 0; k < 50 && !core_ap_start; k++) tick();
        n = 0;
        while (!status_TVALID && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 100) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d want=100", n);
        end
        checks++;
        if (status_TDATA !== 32'h8000_0000) begin
            failures++;
            $display("FAIL timeout_status got=%h want=80000000", status_TDATA);
        end
        status_TREADY = 1'b1;
        tick();
        status_TREADY = 1'b0;
        checks++;
        if (jobs_done !== 16'd1) begin
            failures++;
            $display("FAIL timeout_jobs got=%0d want=1", jobs_done);
        end
        push(10'd5, 10'd5, pok);
        push(10'd6, 10'd6, pok);
        for (int k = 0; k < 50 && !core_ap_start; k++) tick();
        repeat (10) tick();
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({req_TREADY, busy, crop_Y1_TVALID, crop_X1_TVALID, core_ap_start, status_TVALID, jobs_done, status_TDATA} !== 54'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%0d/%h want=0", {req_TREADY, busy, crop_Y1_TVALID, crop_X1_TVALID, core_ap_start, status_TVALID}, jobs_done, status_TDATA);
        end
        repeat (2) tick();
        ap_rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, req_TREADY} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_empty got=%b want=01", {busy, req_TREADY});
        end
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (crop_Y1_TVALID || status_TVALID) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL midreset_dropped got=job want=none");
        end
        push(10'd40, 10'd41, pok);
        run_job(3, y, x, st, sw, ok);
        checks++;
        if (!ok || {y, x} !== {10'd40, 10'd41} || st !== 32'h0 || jobs_done !== 16'd1) begin
            failures++;
            $display("FAIL midreset_restart got=%0d,%0d,%h,%0d want=40,41,00000000,1", y, x, st, jobs_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clamp();
        test_fifo_full();
        test_handshake_order();
        test_timeout_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crop_job_scheduler.md
Name: crop_job_scheduler

Overview:
Sequencer that sits in front of crop_plus_gaussian and runs a queue of crop jobs back-to-back without testbench or host intervention.
- Accepts crop requests (Y1, X1) on an AXI-stream port and buffers them in a small FIFO.
- For each job: delivers the coordinates on the core's crop_Y1/crop_X1 streams, pulses ap_start, and waits for ap_done.
- Emits one status word per job; the image and CNN-output streams do not pass through this block.

Parameters:
IMG_ROW_BITWIDTH, 10, width of Y1
IMG_COL_BITWIDTH, 10, width of X1
IN_ROWS, 100, input image rows
IN_COLS, 160, input image cols
OUT_ROWS, 48, crop height
OUT_COLS, 48, crop width
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 65535, max cycles waiting for ap_done; 0 disables timeout

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
req_TDATA  in  IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH  {Y1, X1}, X1 in LSBs
req_TVALID  in  1  request valid
req_TREADY  out  1  FIFO not full
crop_Y1_TDATA  out  IMG_ROW_BITWIDTH  Y1 to core
crop_Y1_TVALID  out  1
crop_Y1_TREADY  in  1
crop_X1_TDATA  out  IMG_COL_BITWIDTH  X1 to core
crop_X1_TVALID  out  1
crop_X1_TREADY  in  1
core_ap_start  out  1  start pulse to core
core_ap_idle  in  1  core idle
core_ap_done  in  1  core done
status_TDATA  out  32  job status
status_TVALID  out  1
status_TREADY  in  1
busy  out  1  FSM not IDLE or FIFO non-empty
jobs_done  out  16  completed-job count, wraps

Behaviour:
- Reset (async assert, sync deassert): FSM->IDLE; FIFO emptied; job_id=0; jobs_done=0; all TVALIDs, core_ap_start, busy, req_TREADY = 0 while in reset; all TDATA = 0.
- req_TREADY = !fifo_full, registered. No push when full, even if a pop occurs in the same cycle. Simultaneous push and pop when not full: both take effect, count unchanged.
- Clamp on pop:
  - Y1 > IN_ROWS-OUT_ROWS -> Y1 = IN_ROWS-OUT_ROWS.
  - X1 > IN_COLS-OUT_COLS -> X1 = IN_COLS-OUT_COLS.
  - Either clamp sets the job's clamped flag.
- IDLE: if FIFO non-empty, pop at the edge, latch the clamped Y1/X1, go to SEND_COORD. If empty, stay.
- Minimum latency: request handshake at edge N -> crop TVALIDs high after edge N+2.
- SEND_COORD:
  - crop_Y1_TVALID and crop_X1_TVALID both assert on entry.
  - Each deasserts independently after its own handshake (TVALID&TREADY). TDATA is stable while TVALID is high.
  - When both have handshaked (same or different cycles) -> START.
- START: wait until core_ap_idle=1, then drive core_ap_start high for exactly one cycle -> WAIT_DONE.
- WAIT_DONE:
  - A timeout counter starts at 0.
  - core_ap_done=1 -> REPORT with timeout=0.
  - Counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0) -> REPORT with timeout=1.
  - If done and timeout occur in the same cycle, done wins.
- core_ap_done in any state other than WAIT_DONE is ignored.
- REPORT:
  - status_TVALID=1.
  - status_TDATA: [31] timeout, [30] clamped, [29:16] 0, [15:0] job_id.
  - TDATA is held until the handshake.
  - On handshake: job_id++ (wraps), jobs_done++ (wraps) -> IDLE.
- FIFO keeps accepting requests in every state.
- Reset mid-job drops the current and queued jobs; no status is emitted for them.

Test Plan:
- Single request {Y1=37, X1=59}, all readies=1, core_ap_done 20 cycles after start -> crop_Y1=37, crop_X1=59 handshake; one-cycle core_ap_start; status=0x00000000; jobs_done=1.
- Requests (0,0), (37,59), (52,112) pushed back-to-back with core_ap_idle=1 -> three runs in order; status job_id 0, 1, 2; jobs_done=3; busy falls after the last status handshake.
- Request (70,150) -> clamped to Y1=52, X1=112; status[30]=1.
- Push 5 requests with the FSM stalled in SEND_COORD (crop_*_TREADY=0) -> FIFO_DEPTH=4: req_TREADY low after 4 pushes plus the one popped; no request lost or duplicated.
- crop_X1_TREADY delayed 5 cycles after Y1 handshake; core_ap_idle=0 for 3 cycles -> core_ap_start only after both handshakes and after ap_idle=1; spurious core_ap_done during SEND_COORD ignored.
- TIMEOUT_CYCLES=100, core_ap_done never asserted -> status=0x80000000 after 100 cycles in WAIT_DONE. Reset asserted mid-WAIT_DONE -> outputs 0, FIFO empty, job_id restarts at 0.
